change_dispenser: RTL and testbench

Payout side of the vending datapath. The candy FSM accepts coins; this block returns change as coins. It takes a refund amount in nickel units and drives a coin hopper with one-cycle eject pulses: quarters, dimes, nickels, chosen greedily. Each eject is handshaked with the hopper. The block tracks per-denomination inventory and reports full payout, short payout (inventory exhausted) or hopper jam.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/coin_selector.sv | 31 +++
 rtl/change_dispenser.sv | 178 +++++++++++++++++
 tb/tb_change_dispenser.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, payout FSM states, coin-select codes.
package vend_pkg;

  // Coin values expressed in nickel units (1 unit = 5 cents).
  localparam int unsigned Q_VAL = 5;
  localparam int unsigned D_VAL = 2;
  localparam int unsigned N_VAL = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_Q    = 2'd1,
    SEL_D    = 2'd2,
    SEL_N    = 2'd3
  } coin_sel_e;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin pick: largest coin that fits the remaining amount and is in stock.
module coin_selector
  import vend_pkg::*;
#(
  parameter int AMT_W = 6,
  parameter int INV_W = 6
) (
  input  logic [AMT_W-1:0] rem_i,
  input  logic [INV_W-1:0] inv_q_i,
  input  logic [INV_W-1:0] inv_d_i,
  input  logic [INV_W-1:0] inv_n_i,
  output coin_sel_e        sel_o
);

  localparam logic [AMT_W-1:0] Q_AMT = AMT_W'(Q_VAL);
  localparam logic [AMT_W-1:0] D_AMT = AMT_W'(D_VAL);
  localparam logic [AMT_W-1:0] N_AMT = AMT_W'(N_VAL);

  // Priority pick; SEL_NONE means nothing more can be paid.
  always_comb begin
    sel_o = SEL_NONE;
    if (rem_i >= Q_AMT && inv_q_i != '0) begin
      sel_o = SEL_Q;
    end else if (rem_i >= D_AMT && inv_d_i != '0) begin
      sel_o = SEL_D;
    end else if (rem_i >= N_AMT && inv_n_i != '0) begin
      sel_o = SEL_N;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: pays a refund greedily through a handshaked coin hopper,
// tracks per-coin inventory and reports full, short or jammed payouts.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W   = 6,
  parameter int INV_W   = 6,
  parameter int Q_INIT  = 20,
  parameter int D_INIT  = 20,
  parameter int N_INIT  = 20,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  input  logic             hop_done,
  output logic             ready,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  output logic             done,
  output logic             short,
  output logic             jam,
  output logic [AMT_W-1:0] remainder,
  output logic [INV_W-1:0] inv_q,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_n
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  coin_sel_e        sel_q, sel_d, pick;
  logic [AMT_W-1:0] rem_q, rem_d, remainder_q, remainder_d, coin_val;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [INV_W-1:0] qcnt_q, qcnt_d, dcnt_q, dcnt_d, ncnt_q, ncnt_d;
  logic             ready_q, ready_d, ejq_q, ejq_d, ejd_q, ejd_d, ejn_q, ejn_d;
  logic             done_q, done_d, short_q, short_d, jam_q, jam_d;

  coin_selector #(.AMT_W(AMT_W), .INV_W(INV_W)) u_sel (
    .rem_i   (rem_q),
    .inv_q_i (qcnt_q),
    .inv_d_i (dcnt_q),
    .inv_n_i (ncnt_q),
    .sel_o   (pick)
  );

  // Value of the coin currently in flight, used when the hopper confirms the drop.
  always_comb begin
    case (sel_q)
      SEL_Q:   coin_val = AMT_W'(Q_VAL);
      SEL_D:   coin_val = AMT_W'(D_VAL);
      SEL_N:   coin_val = AMT_W'(N_VAL);
      default: coin_val = '0;
    endcase
  end

  // Next-state logic; registered outputs are derived from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sel_d       = sel_q;
    tmo_d       = tmo_q;
    qcnt_d      = qcnt_q;
    dcnt_d      = dcnt_q;
    ncnt_d      = ncnt_q;
    jam_d       = jam_q;
    remainder_d = remainder_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          rem_d       = amount;
          remainder_d = '0;
          state_d     = ST_SELECT;
        end else if (refill) begin
          qcnt_d = INV_W'(Q_INIT);
          dcnt_d = INV_W'(D_INIT);
          ncnt_d = INV_W'(N_INIT);
        end
      end
      ST_SELECT: begin
        sel_d   = pick;
        state_d = (pick == SEL_NONE) ? ST_FIN : ST_EJECT;
      end
      ST_EJECT: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hop_done) begin
          case (sel_q)
            SEL_Q:   qcnt_d = qcnt_q - INV_W'(1);
            SEL_D:   dcnt_d = dcnt_q - INV_W'(1);
            SEL_N:   ncnt_d = ncnt_q - INV_W'(1);
            default: ;
          endcase
          rem_d   = rem_q - coin_val;
          state_d = ST_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          // Coin never confirmed: leave rem and inventory as they were.
          jam_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_FIN) begin
      remainder_d = rem_d;
    end
    ready_d = (state_d == ST_IDLE);
    ejq_d   = (state_d == ST_EJECT) && (sel_d == SEL_Q);
    ejd_d   = (state_d == ST_EJECT) && (sel_d == SEL_D);
    ejn_d   = (state_d == ST_EJECT) && (sel_d == SEL_N);
    done_d  = (state_d == ST_FIN);
    short_d = (state_d == ST_FIN) && (rem_d != '0);
  end

  // State, datapath and output registers; reset aborts any payout in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      sel_q       <= SEL_NONE;
      tmo_q       <= '0;
      qcnt_q      <= INV_W'(Q_INIT);
      dcnt_q      <= INV_W'(D_INIT);
      ncnt_q      <= INV_W'(N_INIT);
      ready_q     <= 1'b1;
      ejq_q       <= 1'b0;
      ejd_q       <= 1'b0;
      ejn_q       <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      jam_q       <= 1'b0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      tmo_q       <= tmo_d;
      qcnt_q      <= qcnt_d;
      dcnt_q      <= dcnt_d;
      ncnt_q      <= ncnt_d;
      ready_q     <= ready_d;
      ejq_q       <= ejq_d;
      ejd_q       <= ejd_d;
      ejn_q       <= ejn_d;
      done_q      <= done_d;
      short_q     <= short_d;
      jam_q       <= jam_d;
      remainder_q <= remainder_d;
    end
  end

  assign ready     = ready_q;
  assign eject_q   = ejq_q;
  assign eject_d   = ejd_q;
  assign eject_n   = ejn_q;
  assign done      = done_q;
  assign short     = short_q;
  assign jam       = jam_q;
  assign remainder = remainder_q;
  assign inv_q     = qcnt_q;
  assign inv_d     = dcnt_q;
  assign inv_n     = ncnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three instances with different initial inventories,
// a vector table of payouts, an eject scoreboard, and hand-written reset/refill cases.
module tb_change_dispenser;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req [NI];
  logic       refill [NI];
  logic       hop_done [NI];
  logic [5:0] amount [NI];
  logic       ready [NI];
  logic       ej_q [NI];
  logic       ej_d [NI];
  logic       ej_n [NI];
  logic       done [NI];
  logic       short_v [NI];
  logic       jam [NI];
  logic [5:0] remainder [NI];
  logic [5:0] inv_q [NI];
  logic [5:0] inv_d [NI];
  logic [5:0] inv_n [NI];

  always #5 clk = ~clk;

  // Instance 0: default stock; 1: a single quarter; 2: no dimes, no nickels.
  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      change_dispenser #(
        .AMT_W(6), .INV_W(6),
        .Q_INIT(gi == 1 ? 1 : 20),
        .D_INIT(gi == 2 ? 0 : 20),
        .N_INIT(gi == 2 ? 0 : 20),
        .TIMEOUT(15)
      ) u_dut (
        .clk(clk), .rst(rst), .req(req[gi]), .amount(amount[gi]),
        .refill(refill[gi]), .hop_done(hop_done[gi]), .ready(ready[gi]),
        .eject_q(ej_q[gi]), .eject_d(ej_d[gi]), .eject_n(ej_n[gi]),
        .done(done[gi]), .short(short_v[gi]), .jam(jam[gi]),
        .remainder(remainder[gi]), .inv_q(inv_q[gi]), .inv_d(inv_d[gi]),
        .inv_n(inv_n[gi])
      );
    end
  endgenerate

  typedef struct {
    int inst, amt, hop, nq, nd, nn, shrt, rem, jm, iq, id, inn, dlat;
  } vec_t;

  vec_t vecs [10];
  int   exp_q [$];   // expected coin codes: 1=Q 2=D 3=N
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur = 0;
  bit   hop_en = 1'b0;
  int   hop_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Eject scoreboard plus an automatic hopper that acks 3 cycles after each eject.
  initial begin
    for (int i = 0; i < NI; i++) hop_done[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        for (int i = 0; i < NI; i++) begin
          int cnt;
          cnt = int'(ej_q[i]) + int'(ej_d[i]) + int'(ej_n[i]);
          if (cnt != 0) begin
            if (i != cur) begin
              chk("stray_eject_inst", i, cur);
            end else begin
              int code;
              code = ej_q[i] ? 1 : (ej_d[i] ? 2 : 3);
              chk("eject_exclusive", cnt, 1);
              if (exp_q.size() == 0) begin
                chk("unexpected_eject", code, 0);
              end else begin
                chk("eject_coin", code, exp_q.pop_front());
              end
            end
          end
        end
        if (hop_en) begin
          if (hop_done[cur]) hop_done[cur] = 1'b0;
          if (hop_cnt > 0) begin
            hop_cnt--;
            if (hop_cnt == 0) hop_done[cur] = 1'b1;
          end
          if (ej_q[cur] || ej_d[cur] || ej_n[cur]) hop_cnt = 3;
        end
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int lat, first, got;
    cur = v.inst;
    hop_en = (v.hop != 0);
    hop_cnt = 0;
    for (int k = 0; k < v.nq; k++) exp_q.push_back(1);
    for (int k = 0; k < v.nd; k++) exp_q.push_back(2);
    for (int k = 0; k < v.nn; k++) exp_q.push_back(3);
    @(negedge clk);
    amount[cur] = v.amt[5:0];
    req[cur] = 1'b1;
    lat = 0; first = -1; got = 0;
    while (got == 0 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req[cur] = 1'b0;
      if (first < 0 && (ej_q[cur] || ej_d[cur] || ej_n[cur])) first = lat;
      if (done[cur]) got = 1;
    end
    $display("vec %0d: inst %0d amount %0d -> done=%0d lat=%0d short=%0d rem=%0d jam=%0d inv=%0d/%0d/%0d",
             idx, v.inst, v.amt, got, lat, short_v[cur], remainder[cur], jam[cur],
             inv_q[cur], inv_d[cur], inv_n[cur]);
    chk("done_seen", got, 1);
    if (got != 0) begin
      if (v.dlat != 0) chk("done_latency", lat, v.dlat);
      if (v.nq + v.nd + v.nn > 0) chk("first_eject_latency", first, 2);
      chk("short", int'(short_v[cur]), v.shrt);
      chk("remainder", int'(remainder[cur]), v.rem);
      chk("jam", int'(jam[cur]), v.jm);
      chk("inv_q", int'(inv_q[cur]), v.iq);
      chk("inv_d", int'(inv_d[cur]), v.id);
      chk("inv_n", int'(inv_n[cur]), v.inn);
      chk("ready_during_done", int'(ready[cur]), 0);
    end
    chk("pending_ejects", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", int'(done[cur]), 0);
    chk("ready_after_done", int'(ready[cur]), 1);
    chk("remainder_held", int'(remainder[cur]), v.rem);
  endtask

  initial begin
    int lat, seen;
    //             inst amt hop nq nd nn shrt rem jam iq id in dlat
    vecs[0] = '{0,  8, 1,  1, 1, 1, 0, 0, 0, 19, 19, 19, 0};
    vecs[1] = '{0,  0, 1,  0, 0, 0, 0, 0, 0, 19, 19, 19, 2};
    vecs[2] = '{0, 63, 1, 12, 1, 1, 0, 0, 0,  7, 18, 18, 0};
    vecs[3] = '{1, 10, 1,  1, 2, 1, 0, 0, 0,  0, 18, 19, 0};
    vecs[4] = '{1,  5, 1,  0, 2, 1, 0, 0, 0,  0, 16, 18, 0};
    vecs[5] = '{2,  7, 1,  1, 0, 0, 1, 2, 0, 19,  0,  0, 0};
    vecs[6] = '{2,  1, 1,  0, 0, 0, 1, 1, 0, 19,  0,  0, 2};
    vecs[7] = '{2,  5, 1,  1, 0, 0, 0, 0, 0, 18,  0,  0, 0};
    vecs[8] = '{0,  3, 0,  0, 1, 0, 1, 3, 1,  7, 18, 18, 0};
    vecs[9] = '{0,  4, 0,  0, 1, 0, 1, 4, 1,  7, 18, 18, 0};

    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; refill[i] = 1'b0; amount[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready[0]), 1);
    chk("rst_ejects", int'(ej_q[0]) + int'(ej_d[0]) + int'(ej_n[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_short", int'(short_v[0]), 0);
    chk("rst_jam", int'(jam[0]), 0);
    chk("rst_remainder", int'(remainder[0]), 0);
    chk("rst_inv_q0", int'(inv_q[0]), 20);
    chk("rst_inv_q1", int'(inv_q[1]), 1);
    chk("rst_inv_d2", int'(inv_d[2]), 0);
    $display("reset: ready=%0d jam=%0d inv0=%0d/%0d/%0d", ready[0], jam[0], inv_q[0], inv_d[0], inv_n[0]);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Refill in IDLE restores instance 1 stock.
    cur = 1; hop_en = 1'b0;
    @(negedge clk); refill[1] = 1'b1;
    @(negedge clk); refill[1] = 1'b0;
    $display("refill inst1: inv=%0d/%0d/%0d", inv_q[1], inv_d[1], inv_n[1]);
    chk("refill_inv_q", int'(inv_q[1]), 1);
    chk("refill_inv_d", int'(inv_d[1]), 20);
    chk("refill_inv_n", int'(inv_n[1]), 18 + 2);

    // req and refill together: req wins, refill ignored.
    cur = 2;
    @(negedge clk); req[2] = 1'b1; refill[2] = 1'b1; amount[2] = 6'd0;
    @(negedge clk); req[2] = 1'b0; refill[2] = 1'b0;
    seen = 0; lat = 0;
    while (seen == 0 && lat < 10) begin
      @(negedge clk); lat++;
      if (done[2]) seen = 1;
    end
    $display("req+refill inst2: done=%0d inv=%0d/%0d/%0d", seen, inv_q[2], inv_d[2], inv_n[2]);
    chk("reqrefill_done", seen, 1);
    chk("reqrefill_inv_q", int'(inv_q[2]), 18);
    chk("reqrefill_inv_d", int'(inv_d[2]), 0);

    // Reset clears the sticky jam and restores stock.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    $display("rst after jam: jam=%0d ready=%0d inv0=%0d", jam[0], ready[0], inv_q[0]);
    chk("jam_cleared", int'(jam[0]), 0);
    chk("jam_rst_inv_q", int'(inv_q[0]), 20);
    chk("jam_rst_remainder", int'(remainder[0]), 0);

    // Reset in WAIT of the second coin, with busy req/refill ignored first.
    cur = 0; hop_en = 1'b0;
    exp_q.push_back(1); exp_q.push_back(2);
    @(negedge clk); amount[0] = 6'd8; req[0] = 1'b1;
    @(negedge clk); req[0] = 1'b0;
    seen = 0; lat = 0;
    while (seen == 0 && lat < 20) begin
      if (ej_q[0]) seen = 1; else begin @(negedge clk); lat++; end
    end
    chk("abort_first_eject", seen, 1);
    @(negedge clk); hop_done[0] = 1'b1;
    @(negedge clk); hop_done[0] = 1'b0;
    chk("abort_inv_q_after_ack", int'(inv_q[0]), 19);
    seen = 0; lat = 0;
    while (seen == 0 && lat < 20) begin
      if (ej_d[0]) seen = 1; else begin @(negedge clk); lat++; end
    end
    chk("abort_second_eject", seen, 1);
    @(negedge clk); req[0] = 1'b1; amount[0] = 6'd63; refill[0] = 1'b1;
    @(negedge clk); req[0] = 1'b0; refill[0] = 1'b0;
    chk("busy_ready", int'(ready[0]), 0);
    chk("busy_refill_inv_q", int'(inv_q[0]), 19);
    chk("busy_inv_d", int'(inv_d[0]), 20);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    $display("rst mid-payout: ready=%0d done=%0d inv=%0d/%0d/%0d", ready[0], done[0], inv_q[0], inv_d[0], inv_n[0]);
    chk("abort_ready", int'(ready[0]), 1);
    chk("abort_inv_q", int'(inv_q[0]), 20);
    chk("abort_inv_d", int'(inv_d[0]), 20);
    seen = 0;
    if (done[0]) seen++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_pending_ejects", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
